dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer for the shared single-ported byte-addressed data memory of the RV32I core. It sits between the instruction-fetch unit (requester 0) and the load/store unit (requester 1) on one side and the data memory on the other. It accepts one request at a time with round-robin fairness and converts RV32I `funct3` sizes into word-aligned memory accesses with byte enables. It holds the memory inputs stable for the fixed access latency, then returns formatted load data or a store acknowledge.

## Interface
- ADDR_W, 12, byte-address width.
- MEM_LAT, 4, cycles `mem_en_o` is held per access; must be ≥1.

- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- rq0_valid_i / rq1_valid_i  in  1  request valid.
- rq0_ready_o / rq1_ready_o  out  1  request accepted this cycle.
- rqN_addr_i  in  ADDR_W  byte address.
- rqN_we_i  in  1  1 = store.
- rqN_size_i  in  3  RV32I `funct3`: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- rqN_wdata_i  in  32  store data, LSB-aligned.
- rqN_rvalid_o  out  1  one-cycle response strobe.
- rqN_rdata_o  out  32  formatted load data; 0 for stores and errors.
- rqN_err_o  out  1  qualifies rvalid: misaligned access or illegal size.
- mem_en_o  out  1  access active.
- mem_we_o  out  1  write.
- mem_addr_o  out  ADDR_W  word address, bits [1:0] = 0.
- mem_be_o  out  4  byte-lane enables.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rdata_i  in  32  word read data; valid in the last access cycle.

## Operation
- FSM states:
  - IDLE → ACCESS on a legal request.
  - IDLE → RESP on an error request.
  - ACCESS → RESP when `cnt == MEM_LAT-1`.
  - RESP → IDLE unconditionally.
- Arbitration happens in IDLE only:
  - One valid requester: it is granted.
  - Both valid: grant the requester that was not granted most recently.
  - The granting pointer `last` updates on every handshake, including error requests.
- Handshake: `rqN_ready_o` is asserted combinationally in IDLE for the winner only; the transaction is accepted when `valid & ready`.
- Address, `we`, `size` and `wdata` are latched at accept. Requester inputs are don't-care afterwards.
- Error requests make no memory access:
  - Illegal size: 3, 6 or 7 for loads; anything other than 0, 1 or 2 for stores.
  - H/HU with `addr[0]` = 1.
  - W with `addr[1:0]` ≠ 0.
- Store lanes:
  - B: `be = 1 << addr[1:0]`; wdata byte replicated ×4.
  - H: `be = 3 << addr[1:0]`; halfword replicated ×2.
  - W: `be = 4'hF`.
  - `be` is 4'hF for loads.
- Load formatting:
  - `word >> (8*addr[1:0])`.
  - B/H are sign-extended; BU/HU are zero-extended.
- Only the granted requester's rvalid/rdata/err are driven; the other port outputs 0.
- Reset:
  - State returns to IDLE, `cnt` = 0, `last` = 1, so requester 0 wins the first tie.
  - All outputs are 0.
  - An access in progress is abandoned with no rvalid.

## Timing
- Accept at cycle T.
- Cycles T+1 … T+MEM_LAT: ACCESS. `mem_en_o` = 1 and `mem_addr_o`, `mem_we_o`, `mem_be_o`, `mem_wdata_o` are constant throughout.
- `mem_rdata_i` is sampled at the end of cycle T+MEM_LAT.
- Cycle T+MEM_LAT+1: RESP, `rvalid` = 1 for one cycle.
- Error path: RESP at T+1.
- Earliest next accept is the cycle after RESP. Legal-access throughput is one per MEM_LAT+2 cycles.
- The memory-side outputs are registered; all memory outputs are 0 outside ACCESS.

## Structure
- `dmem_pkg` contains:
  - State enum: IDLE, ACCESS, RESP.
  - `funct3` constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The `is_legal(we, size, addr)` function.
- Sub-module `dmem_lane_fmt` (combinational) holds the store lane and `be` generation plus load shift and extension, shared by the store and load paths.

## Test plan
- Reset, then rq0 LW at 0x010 with MEM_LAT = 4 and memory word 0xDEADBEEF:
  - ready at T.
  - `mem_en_o` high for 4 cycles with `mem_addr_o` = 0x010.
  - rq0_rvalid at T+5 with rdata = 0xDEADBEEF.
- rq1 SB at 0x013 with wdata = 0x000000A5: `mem_be_o` = 4'b1000, `mem_wdata_o` = 0xA5A5A5A5, rvalid with rdata = 0.
- LB at 0x013 returns 0xFFFFFFDE; LBU at 0x013 returns 0x000000DE; LH at 0x012 returns 0xFFFFDEAD (word 0xDEADBEEF).
- Both requesters valid continuously for 4 transactions: grants alternate 0, 1, 0, 1; rvalid never reaches the non-granted port.
- LW at 0x011 and LH at 0x003: no `mem_en_o`, err with rvalid at T+1, rdata = 0.
- Assert `reset_i` in the 2nd ACCESS cycle: all outputs go to 0 immediately, no rvalid follows, and the next request is served normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types, RV32I funct3 size codes and legality check for the
//             data-memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Stores accept only B/H/W; loads additionally accept the unsigned forms.
    function automatic logic is_legal(input logic       we,
                                      input logic [2:0] size,
                                      input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = !we;
            F3_HU:   ok = !we && !addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
// ============================================================================
//  Module   : dmem_lane_fmt
//  Purpose  : Store byte-lane/enable generation and load shift/extension.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic        st_we,
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane_data,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] w_shifted;

    always_comb begin
        st_be        = 4'hF;
        st_lane_data = st_wdata;
        if (st_we) begin
            case (st_size[1:0])
                2'd0: begin
                    st_be        = 4'b0001 << st_addr_lo;
                    st_lane_data = {4{st_wdata[7:0]}};
                end
                2'd1: begin
                    st_be        = 4'b0011 << st_addr_lo;
                    st_lane_data = {2{st_wdata[15:0]}};
                end
                default: begin
                    st_be        = 4'hF;
                    st_lane_data = st_wdata;
                end
            endcase
        end
    end

    always_comb begin
        w_shifted = ld_word >> {ld_addr_lo, 3'b000};
        case (ld_size)
            F3_B:    ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   ld_data = {24'h0, w_shifted[7:0]};
            F3_HU:   ld_data = {16'h0, w_shifted[15:0]};
            default: ld_data = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin two-port arbiter and fixed-latency access sequencer
//             for the shared single-ported data memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rq0_valid_i,
    output logic              rq0_ready_o,
    input  logic [ADDR_W-1:0] rq0_addr_i,
    input  logic              rq0_we_i,
    input  logic [2:0]        rq0_size_i,
    input  logic [31:0]       rq0_wdata_i,
    output logic              rq0_rvalid_o,
    output logic [31:0]       rq0_rdata_o,
    output logic              rq0_err_o,
    input  logic              rq1_valid_i,
    output logic              rq1_ready_o,
    input  logic [ADDR_W-1:0] rq1_addr_i,
    input  logic              rq1_we_i,
    input  logic [2:0]        rq1_size_i,
    input  logic [31:0]       rq1_wdata_i,
    output logic              rq1_rvalid_o,
    output logic [31:0]       rq1_rdata_o,
    output logic              rq1_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int                 c_CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_LAT - 1);

    dmem_state_e        r_state;
    dmem_state_e        w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last;
    logic               r_gnt;
    logic [1:0]         r_addr_lo;
    logic [2:0]         r_size;

    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [3:0]         r_mem_be;
    logic [31:0]        r_mem_wdata;

    logic               r_rvalid0;
    logic               r_rvalid1;
    logic               r_err;
    logic [31:0]        r_rdata;

    logic               w_win;
    logic               w_any_valid;
    logic [ADDR_W-1:0]  w_req_addr;
    logic               w_req_we;
    logic [2:0]         w_req_size;
    logic [31:0]        w_req_wdata;
    logic               w_legal;
    logic               w_accept;
    logic               w_acc_done;
    logic [3:0]         w_st_be;
    logic [31:0]        w_st_lane;
    logic [31:0]        w_ld_data;

    // On a tie the requester not served most recently wins.
    always_comb begin
        w_any_valid = rq0_valid_i | rq1_valid_i;
        w_win       = (rq0_valid_i && rq1_valid_i) ? ~r_last : rq1_valid_i;
        w_req_addr  = w_win ? rq1_addr_i  : rq0_addr_i;
        w_req_we    = w_win ? rq1_we_i    : rq0_we_i;
        w_req_size  = w_win ? rq1_size_i  : rq0_size_i;
        w_req_wdata = w_win ? rq1_wdata_i : rq0_wdata_i;
        w_legal     = is_legal(w_req_we, w_req_size, w_req_addr[1:0]);
    end

    dmem_lane_fmt u_lane_fmt (
        .st_we        (w_req_we),
        .st_size      (w_req_size),
        .st_addr_lo   (w_req_addr[1:0]),
        .st_wdata     (w_req_wdata),
        .st_be        (w_st_be),
        .st_lane_data (w_st_lane),
        .ld_size      (r_size),
        .ld_addr_lo   (r_addr_lo),
        .ld_word      (mem_rdata_i),
        .ld_data      (w_ld_data)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_acc_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_valid && !reset_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_acc_done  = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_size      <= 3'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0;
            if (w_accept) begin
                r_last    <= w_win;
                r_gnt     <= w_win;
                r_addr_lo <= w_req_addr[1:0];
                r_size    <= w_req_size;
                r_cnt     <= '0;
                if (w_legal) begin
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= w_req_we;
                    r_mem_addr  <= {w_req_addr[ADDR_W-1:2], 2'b00};
                    r_mem_be    <= w_st_be;
                    r_mem_wdata <= w_req_we ? w_st_lane : 32'h0;
                end else begin
                    r_rvalid0 <= ~w_win;
                    r_rvalid1 <= w_win;
                    r_err     <= 1'b1;
                end
            end
            if (r_state == ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_acc_done) begin
                    r_cnt       <= '0;
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_be    <= 4'h0;
                    r_mem_wdata <= 32'h0;
                    r_rvalid0   <= ~r_gnt;
                    r_rvalid1   <= r_gnt;
                    r_rdata     <= r_mem_we ? 32'h0 : w_ld_data;
                end
            end
        end
    end

    assign rq0_ready_o  = w_accept & ~w_win;
    assign rq1_ready_o  = w_accept & w_win;
    assign rq0_rvalid_o = r_rvalid0;
    assign rq1_rvalid_o = r_rvalid1;
    assign rq0_rdata_o  = r_rvalid0 ? r_rdata : 32'h0;
    assign rq1_rdata_o  = r_rvalid1 ? r_rdata : 32'h0;
    assign rq0_err_o    = r_rvalid0 & r_err;
    assign rq1_err_o    = r_rvalid1 & r_err;
    assign mem_en_o     = r_mem_en;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_be_o     = r_mem_be;
    assign mem_wdata_o  = r_mem_wdata;

endmodule

`default_nettype wire
